// File: rtl/ram_str_copier_pkg.sv
// Shared widths, the null terminator and the copier state encoding.
// The bench imports this too, so it can name states when probing.
package ram_str_copier_pkg;

    localparam int WORD_W = 10;
    localparam int ADDR_W = 10;

    localparam logic [WORD_W-1:0] NUL = '0;

    typedef enum logic [2:0] {
        IDLE,
        PSRC,
        PDST,
        RD,
        WR,
        FIN
    } state_e;

endpackage

// File: rtl/ram_str_copier.sv
// Copies a null-terminated string between RAM regions, optionally through pointer words.
// Each word takes one read cycle and one write cycle; all RAM-side outputs are registered.
module ram_str_copier
    import ram_str_copier_pkg::*;
#(
    parameter int MAX_LEN = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              indirect,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] count
);

    localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_LEN);

    state_e            state_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [WORD_W-1:0] data_q;
    // The word count doubles as the offset into both regions.
    logic [ADDR_W-1:0] count_q;
    logic              err_q;
    logic              done_q;
    logic              busy_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [WORD_W-1:0] mem_wdata_q;

    logic [ADDR_W-1:0] count_d;

    assign count_d = count_q + 10'd1;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            data_q      <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q      <= src;
                        dst_q      <= dst;
                        count_q    <= '0;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        // src is either the string itself or its pointer word; both are read first.
                        mem_addr_q <= src;
                        state_q    <= indirect ? PSRC : RD;
                    end
                end
                PSRC: begin
                    src_q      <= mem_rdata;
                    mem_addr_q <= dst_q;
                    state_q    <= PDST;
                end
                PDST: begin
                    dst_q      <= mem_rdata;
                    mem_addr_q <= src_q;
                    state_q    <= RD;
                end
                RD: begin
                    data_q      <= mem_rdata;
                    mem_addr_q  <= dst_q + count_q;
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= mem_rdata;
                    state_q     <= WR;
                end
                WR: begin
                    mem_we_q <= 1'b0;
                    if (data_q == NUL || count_d == MAX_CNT) begin
                        if (data_q != NUL) begin
                            count_q <= count_d;
                            err_q   <= 1'b1;
                        end
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        done_q      <= 1'b1;
                        state_q     <= FIN;
                    end else begin
                        count_q    <= count_d;
                        mem_addr_q <= src_q + count_d;
                        state_q    <= RD;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q     <= 1'b0;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= '0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign count     = count_q;

endmodule

// File: tb/tb_ram_str_copier.sv
// Bench for ram_str_copier: two instances (MAX_LEN 1023 and 4), each with its own 1024x10 RAM,
// checked every cycle against a queue-based model of the expected write sequence.
module tb_ram_str_copier;
    import ram_str_copier_pkg::*;

    typedef struct packed {
        logic [9:0] a;
        logic [9:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic       indirect = 1'b0;
    logic [9:0] src = '0, dst = '0;
    logic       sel = 1'b0;

    logic [9:0] addr_a, wdata_a, rdata_a, count_a;
    logic       we_a, busy_a, done_a, err_a;
    logic [9:0] addr_b, wdata_b, rdata_b, count_b;
    logic       we_b, busy_b, done_b, err_b;

    logic [9:0] m_addr, m_wdata, m_count;
    logic       m_we, m_busy, m_done, m_err;

    logic       pl_we = 1'b0;
    logic [1:0] pl_mask = '0;
    logic [9:0] pl_addr = '0, pl_data = '0;

    logic [9:0] ram_a [1024];
    logic [9:0] ram_b [1024];
    logic [9:0] img_a [1024];
    logic [9:0] img_b [1024];
    wr_t        exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign rdata_a = ram_a[addr_a];
    assign rdata_b = ram_b[addr_b];

    always @(posedge clk) begin
        if (we_a) ram_a[addr_a] <= wdata_a;
        if (we_b) ram_b[addr_b] <= wdata_b;
        if (pl_we && pl_mask[0]) ram_a[pl_addr] <= pl_data;
        if (pl_we && pl_mask[1]) ram_b[pl_addr] <= pl_data;
    end

    ram_str_copier #(.MAX_LEN(1023)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .indirect(indirect), .src(src), .dst(dst),
        .mem_addr(addr_a), .mem_we(we_a), .mem_wdata(wdata_a), .mem_rdata(rdata_a),
        .busy(busy_a), .done(done_a), .err(err_a), .count(count_a)
    );

    ram_str_copier #(.MAX_LEN(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .indirect(indirect), .src(src), .dst(dst),
        .mem_addr(addr_b), .mem_we(we_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
        .busy(busy_b), .done(done_b), .err(err_b), .count(count_b)
    );

    always_comb begin
        m_addr  = sel ? addr_b  : addr_a;
        m_wdata = sel ? wdata_b : wdata_a;
        m_count = sel ? count_b : count_a;
        m_we    = sel ? we_b    : we_a;
        m_busy  = sel ? busy_b  : busy_a;
        m_done  = sel ? done_b  : done_a;
        m_err   = sel ? err_b   : err_a;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    task automatic put(input logic [1:0] m, input logic [9:0] a, input logic [9:0] v);
        @(negedge clk);
        pl_we = 1'b1; pl_mask = m; pl_addr = a; pl_data = v;
        if (m[0]) img_a[a] = v;
        if (m[1]) img_b[a] = v;
        @(posedge clk);
        #1 pl_we = 1'b0;
    endtask

    // Reference: walk the string in a private copy of the image, one read then one write per word.
    task automatic model(input bit use_b, input bit ind, input logic [9:0] s, input logic [9:0] d,
                         input int maxl, output int cnt, output bit er, output int cyc);
        logic [9:0] w [1024];
        logic [9:0] ps, pd, v;
        for (int i = 0; i < 1024; i++) w[i] = use_b ? img_b[i] : img_a[i];
        exp_q.delete();
        cnt = 0;
        er  = 1'b0;
        ps  = ind ? w[s] : s;
        pd  = ind ? w[d] : d;
        for (int k = 0; k < 1024; k++) begin
            v = w[10'(ps + k)];
            w[10'(pd + k)] = v;
            exp_q.push_back('{a: 10'(pd + k), d: v});
            if (v == 10'd0) break;
            cnt++;
            if (cnt == maxl) begin
                er = 1'b1;
                break;
            end
        end
        cyc = 2 * exp_q.size() + 1 + (ind ? 2 : 0);
    endtask

    task automatic ram_compare(input bit use_b, input string tag);
        int bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (use_b ? (ram_b[i] !== img_b[i]) : (ram_a[i] !== img_a[i])) bad++;
        end
        check({tag, "_ram_image_mismatches"}, bad, 0);
    endtask

    task automatic run_copy(input bit use_b, input bit ind, input logic [9:0] s, input logic [9:0] d,
                            input int lit_cnt, input int lit_cyc, input int lit_err,
                            input int rst_at, input string tag);
        int  ecnt, ecyc, n, nw;
        bit  eerr;
        wr_t e;
        model(use_b, ind, s, d, use_b ? 4 : 1023, ecnt, eerr, ecyc);
        if (lit_cnt >= 0) check({tag, "_model_count"}, ecnt, lit_cnt);
        if (lit_cyc >= 0) check({tag, "_model_cycles"}, ecyc, lit_cyc);
        if (lit_err >= 0) check({tag, "_model_err"}, eerr, lit_err);
        sel = use_b;
        @(negedge clk);
        indirect = ind; src = s; dst = d;
        set_start(1'b1);
        @(posedge clk);
        #1 set_start(1'b0);
        n  = 1;
        nw = 0;
        while (1) begin
            if (n == 3) set_start(1'b0);
            check({tag, "_busy_while_copying"}, m_busy, 1);
            if (m_we) begin
                if (nw == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    check({tag, "_rst_we"}, m_we, 0);
                    check({tag, "_rst_busy"}, m_busy, 0);
                    check({tag, "_rst_count"}, m_count, 0);
                    check({tag, "_rst_addr"}, m_addr, 0);
                    check({tag, "_rst_state"}, 32'(use_b ? dut_b.state_q : dut_a.state_q), 32'(IDLE));
                    @(posedge clk);
                    #1 ram_compare(use_b, tag);
                    return;
                end
                check({tag, "_write_expected"}, exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({tag, "_write_addr"}, m_addr, e.a);
                    check({tag, "_write_data"}, m_wdata, e.d);
                    if (use_b) img_b[e.a] = e.d;
                    else       img_a[e.a] = e.d;
                end
                nw++;
            end
            if (m_done) begin
                check({tag, "_fin_addr"}, m_addr, 0);
                check({tag, "_fin_wdata"}, m_wdata, 0);
                check({tag, "_fin_we"}, m_we, 0);
                break;
            end
            if (n >= 2200) begin
                check({tag, "_done_timeout_cycle"}, n, ecyc);
                break;
            end
            if (n == 2) begin
                src = s + 10'd5;
                set_start(1'b1);
            end
            @(posedge clk);
            #1 n++;
        end
        set_start(1'b0);
        check({tag, "_done_cycle"}, n, ecyc);
        check({tag, "_count"}, m_count, ecnt);
        check({tag, "_err"}, m_err, eerr);
        check({tag, "_writes_left"}, exp_q.size(), 0);
        if (lit_cnt >= 0) check({tag, "_count_literal"}, m_count, lit_cnt);
        if (lit_err >= 0) check({tag, "_err_literal"}, m_err, lit_err);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse_ends"}, m_done, 0);
        check({tag, "_busy_falls"}, m_busy, 0);
        check({tag, "_count_held"}, m_count, ecnt);
        check({tag, "_err_held"}, m_err, eerr);
        check({tag, "_idle_addr"}, m_addr, 0);
        check({tag, "_idle_we"}, m_we, 0);
        ram_compare(use_b, tag);
    endtask

    initial begin : stim
        string      waffle;
        logic [9:0] s, d, ps, pd;
        int         len;
        bit         ub, ind;

        waffle = "WafflesAndPancakes";
        for (int i = 0; i < 1024; i++) put(2'b11, 10'(i), 10'($urandom_range(1, 1023)));

        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_err", err_a, 0);
        check("reset_count", count_a, 0);
        check("reset_we", we_a, 0);
        check("reset_addr", addr_a, 0);
        check("reset_wdata", wdata_a, 0);
        check("reset_state", 32'(dut_a.state_q), 32'(IDLE));

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < waffle.len(); i++) put(2'b01, 10'(3 + i), 10'(waffle[i]));
        put(2'b01, 10'd21, 10'd0);
        run_copy(1'b0, 1'b0, 10'd3, 10'd576, 18, 39, 0, -1, "direct");

        put(2'b01, 10'd0, 10'd576);
        put(2'b01, 10'd1, 10'd600);
        put(2'b01, 10'd576, 10'(8'h48));
        put(2'b01, 10'd577, 10'(8'h69));
        put(2'b01, 10'd578, 10'd0);
        run_copy(1'b0, 1'b1, 10'd0, 10'd1, 2, 9, 0, -1, "indirect");
        check("indirect_ram_600", ram_a[600], 10'h48);
        check("indirect_ram_602", ram_a[602], 0);

        put(2'b01, 10'd50, 10'd0);
        run_copy(1'b0, 1'b0, 10'd50, 10'd700, 0, 3, 0, -1, "empty");
        run_copy(1'b0, 1'b0, 10'd50, 10'd700, 0, 3, 0, -1, "back_to_back");

        for (int i = 0; i < 6; i++) put(2'b10, 10'(100 + i), 10'(i + 1));
        put(2'b10, 10'd106, 10'd0);
        put(2'b10, 10'd204, 10'h3FF);
        run_copy(1'b1, 1'b0, 10'd100, 10'd200, 4, 9, 1, -1, "abort");
        check("abort_no_terminator", ram_b[204], 10'h3FF);

        put(2'b01, 10'd1022, 10'd11);
        put(2'b01, 10'd1023, 10'd22);
        put(2'b01, 10'd0, 10'd33);
        put(2'b01, 10'd1, 10'd0);
        run_copy(1'b0, 1'b0, 10'd1022, 10'd300, 3, 9, 0, -1, "wrap");
        check("wrap_ram_302", ram_a[302], 33);

        for (int i = 0; i < 10; i++) put(2'b01, 10'(400 + i), 10'(40 + i));
        put(2'b01, 10'd410, 10'd0);
        for (int i = 0; i < 11; i++) put(2'b01, 10'(800 + i), 10'h3FF);
        run_copy(1'b0, 1'b0, 10'd400, 10'd800, 10, 23, 0, 4, "reset_mid");
        check("reset_mid_word4_unwritten", ram_a[804], 10'h3FF);
        @(negedge clk);
        rst_n = 1'b1;
        run_copy(1'b0, 1'b0, 10'd400, 10'd800, 10, 23, 0, -1, "after_reset");

        for (int it = 0; it < 20; it++) begin
            ub  = 1'($urandom_range(0, 1));
            ind = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 12);
            s   = 10'($urandom);
            d   = 10'($urandom);
            for (int i = 0; i < len; i++) put(ub ? 2'b10 : 2'b01, 10'(s + i), 10'($urandom_range(1, 1023)));
            put(ub ? 2'b10 : 2'b01, 10'(s + len), 10'd0);
            if (ind) begin
                ps = 10'($urandom);
                pd = 10'($urandom);
                put(ub ? 2'b10 : 2'b01, ps, s);
                put(ub ? 2'b10 : 2'b01, pd, d);
                run_copy(ub, 1'b1, ps, pd, -1, -1, -1, -1, "random_indirect");
            end else begin
                run_copy(ub, 1'b0, s, d, -1, -1, -1, -1, "random_direct");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
